// File: rtl/rcd_pkg.sv
//------------------------------------------------------------------------------
// rcd_pkg : scan states and 7-segment glyph constants for rco_cascade_display
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rcd_pkg;

    typedef enum logic [0:0] {
        SHOW_LO = 1'b0,
        SHOW_HI = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Segment order {g,f,e,d,c,b,a}; entry 15 is listed first
    localparam logic [15:0][6:0] SEG_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

`default_nettype wire

// File: rtl/rco_cascade_display_hex7seg.sv
//------------------------------------------------------------------------------
// hex7seg : combinational 4-bit hex to active-high 7-segment decoder
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hex7seg
    import rcd_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_GLYPH[i_hex];

endmodule

`default_nettype wire

// File: rtl/rco_cascade_display.sv
//------------------------------------------------------------------------------
// rco_cascade_display : cascaded high-nibble counter with 2-digit scanned
// 7-segment display. Optional macro LEADING_ZERO_BLANK_EN blanks a zero high digit.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rco_cascade_display
    import rcd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] count_lo,
    input  logic       rco,
    input  logic       clr,
    output logic [3:0] count_hi,
    output logic       rco_hi,
    output logic [6:0] seg,
    output logic [1:0] dig_sel
);

    localparam logic [7:0] c_DIV_LAST = 8'(SCAN_DIV - 1);

    logic        r_rco_q;
    logic        r_armed;
    logic [3:0]  r_count_hi;
    logic [7:0]  r_presc;
    scan_state_t r_state;
    scan_state_t w_state_next;
    logic [7:0]  r_snap;
    logic [6:0]  r_seg;
    logic [1:0]  r_dig_sel;
    logic        w_rco_rise;
    logic        w_presc_wrap;
    logic [3:0]  w_nibble;
    logic [6:0]  w_glyph;
    logic [6:0]  w_seg_next;
    logic [1:0]  w_dig_next;

    // r_armed keeps an rco that is already high at reset release from counting
    assign w_rco_rise   = rco & ~r_rco_q & r_armed;
    assign w_presc_wrap = (r_presc == c_DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rco_q    <= 1'b0;
            r_armed    <= 1'b0;
            r_count_hi <= 4'd0;
        end else begin
            r_rco_q <= rco;
            r_armed <= 1'b1;
            if (clr)
                r_count_hi <= 4'd0;
            else if (w_rco_rise)
                r_count_hi <= r_count_hi + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SHOW_LO;
            r_presc <= 8'd0;
            r_snap  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_wrap ? 8'd0 : r_presc + 8'd1;
            if (w_presc_wrap && (r_state == SHOW_HI))
                r_snap <= {r_count_hi, count_lo};
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dig_next   = 2'b01;
        w_nibble     = r_snap[3:0];
        if (w_presc_wrap)
            w_state_next = (r_state == SHOW_LO) ? SHOW_HI : SHOW_LO;
        if (r_state == SHOW_HI) begin
            w_dig_next = 2'b10;
            w_nibble   = r_snap[7:4];
        end
    end

    hex7seg u_hex7seg (
        .i_hex (w_nibble),
        .o_seg (w_glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign w_seg_next = ((r_state == SHOW_HI) && (r_snap[7:4] == 4'd0)) ? SEG_BLANK : w_glyph;
`else
    assign w_seg_next = w_glyph;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg     <= SEG_GLYPH[0];
            r_dig_sel <= 2'b01;
        end else begin
            r_seg     <= w_seg_next;
            r_dig_sel <= w_dig_next;
        end
    end

    assign count_hi = r_count_hi;
    assign rco_hi   = rco & (r_count_hi == 4'd15);
    assign seg      = r_seg;
    assign dig_sel  = r_dig_sel;

endmodule

`default_nettype wire

// File: tb/tb_rco_cascade_display.sv
//------------------------------------------------------------------------------
// tb_rco_cascade_display : directed self-checking bench for rco_cascade_display
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rco_cascade_display;

    logic       clk;
    logic       rst_n;
    logic [3:0] count_lo;
    logic       rco;
    logic       clr;
    logic [3:0] count_hi;
    logic       rco_hi;
    logic [6:0] seg;
    logic [1:0] dig_sel;

    int n_checks = 0;
    int n_errors = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] c_HI_ZERO = 8'h00;
`else
    localparam logic [7:0] c_HI_ZERO = 8'h3F;
`endif

    rco_cascade_display #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .count_lo (count_lo),
        .rco      (rco),
        .clr      (clr),
        .count_hi (count_hi),
        .rco_hi   (rco_hi),
        .seg      (seg),
        .dig_sel  (dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [1:0] exp_dig, input logic [7:0] exp_seg);
        chk({tag, "_dig"}, {6'd0, dig_sel}, {6'd0, exp_dig});
        chk({tag, "_seg"}, {1'b0, seg}, exp_seg);
    endtask

    initial begin
        logic [3:0] exp_hi;

        rst_n = 1'b0; rco = 1'b0; clr = 1'b0; count_lo = 4'd0;
        tick(2);
        chk("rst_count_hi", {4'd0, count_hi}, 8'h00);
        chk_disp("rst", 2'b01, 8'h3F);
        chk("rst_rco_hi", {7'd0, rco_hi}, 8'h00);

        // Sixteen upstream wraps
        rst_n = 1'b1;
        exp_hi = 4'd0;
        for (int w = 0; w < 16; w++) begin
            for (int v = 0; v < 16; v++) begin
                count_lo = 4'(v);
                rco = (v == 15);
                #1;
                if (v == 15)
                    chk($sformatf("cas_rco_hi_w%0d", w), {7'd0, rco_hi}, {7'd0, (exp_hi == 4'd15)});
                tick(1);
                if (v == 15) begin
                    exp_hi = exp_hi + 4'd1;
                    chk($sformatf("cas_count_w%0d", w), {4'd0, count_hi}, {4'd0, exp_hi});
                end
            end
        end
        rco = 1'b0; count_lo = 4'd0;
        tick(1);

        // rco held high five cycles
        rco = 1'b1;
        tick(1);
        chk("hold_first", {4'd0, count_hi}, 8'h01);
        tick(4);
        chk("hold_fifth", {4'd0, count_hi}, 8'h01);
        rco = 1'b0;
        tick(1);
        chk("hold_after", {4'd0, count_hi}, 8'h01);

        repeat (6) begin
            rco = 1'b1; tick(1);
            rco = 1'b0; tick(1);
        end
        chk("reach_7", {4'd0, count_hi}, 8'h07);

        // clr beats a simultaneous rising rco; rco_q still samples
        rco = 1'b1; clr = 1'b1;
        tick(1);
        chk("clr_wins", {4'd0, count_hi}, 8'h00);
        clr = 1'b0;
        tick(1);
        chk("clr_rcoq_upd", {4'd0, count_hi}, 8'h00);
        rco = 1'b0;
        tick(1);

        // Reset overrides a rising rco; rco high at release is ignored
        rco = 1'b1; tick(1);
        rco = 1'b0; tick(1);
        chk("pre_rst", {4'd0, count_hi}, 8'h01);
        rco = 1'b1; rst_n = 1'b0;
        tick(1);
        chk("rst_override", {4'd0, count_hi}, 8'h00);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("rel_rco_high1", {4'd0, count_hi}, 8'h00);
        tick(1);
        chk("rel_rco_high2", {4'd0, count_hi}, 8'h00);
        rco = 1'b0; tick(1);
        rco = 1'b1; tick(1);
        chk("rel_then_rise", {4'd0, count_hi}, 8'h01);

        // Scan timing from a fresh reset: edges E1.. after release
        rco = 1'b0; rst_n = 1'b0; count_lo = 4'hA;
        tick(2);
        rst_n = 1'b1;
        tick(1);                       // E1
        rco = 1'b1; tick(1);           // E2 -> 1
        rco = 1'b0; tick(1);           // E3
        rco = 1'b1; tick(1);           // E4 -> 2
        chk_disp("scan_e4", 2'b01, 8'h3F);
        rco = 1'b0; tick(1);           // E5
        chk_disp("scan_e5_hi0", 2'b10, c_HI_ZERO);
        rco = 1'b1; tick(1);           // E6 -> 3
        rco = 1'b0; tick(2);           // E8 snapshot {3,A}
        chk("scan_cnt3", {4'd0, count_hi}, 8'h03);
        chk_disp("scan_e8_hi0", 2'b10, c_HI_ZERO);
        tick(1);                       // E9
        chk_disp("scan_e9", 2'b01, 8'h77);
        count_lo = 4'h5;
        tick(3);                       // E12
        chk_disp("scan_e12_hold", 2'b01, 8'h77);
        tick(1);                       // E13
        chk_disp("scan_e13", 2'b10, 8'h4F);
        tick(3);                       // E16 new snapshot {3,5}
        chk_disp("scan_e16", 2'b10, 8'h4F);
        tick(1);                       // E17
        chk_disp("scan_e17", 2'b01, 8'h6D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
